// File: rtl/inst_enc.sv
// inst_enc: micro-op to RV32 R-type re-encoder with an output FIFO.
//
// Takes packed 45-bit decoded micro-ops (inst_t layout) and emits the
// matching 32-bit OP-class ALU instruction word. Encoded words are queued
// in a DEPTH-entry FIFO. Illegal micro-ops are still consumed, but they are
// dropped and reported with a one-cycle err pulse.
//
// Optional feature macro: INST_ENC_ERRCNT_EN adds an 8-bit saturating
// count of dropped micro-ops on err_cnt.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   uop_in[44:0]        {rs1, rs2, rd, imm[19:0], type, op}
//   uop_valid/uop_ready input handshake
//   inst_out[31:0]      encoded word at the FIFO head (0 when empty)
//   inst_valid/inst_ready output handshake
//   err                 one-cycle pulse per dropped illegal micro-op
//   err_cnt[7:0]        saturating drop count (only with INST_ENC_ERRCNT_EN)
module inst_enc #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [44:0] uop_in,
  input  logic        uop_valid,
  output logic        uop_ready,
  output logic [31:0] inst_out,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic        err
`ifdef INST_ENC_ERRCNT_EN
  ,
  output logic [7:0]  err_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [19:0] imm;
    logic [4:0]  typ;
    logic [4:0]  op;
  } uop_t;

  uop_t        uop;
  logic        legal;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] enc;

  assign uop = uop_t'(uop_in);

  // Decode op to (funct3, funct7); anything outside 1..10 is illegal.
  always_comb begin
    f3    = 3'b000;
    f7    = 7'b0000000;
    legal = 1'b1;
    case (uop.op)
      5'd1:    f3 = 3'b000;
      5'd2:    begin f3 = 3'b000; f7 = 7'b0100000; end
      5'd3:    f3 = 3'b001;
      5'd4:    f3 = 3'b010;
      5'd5:    f3 = 3'b011;
      5'd6:    f3 = 3'b100;
      5'd7:    f3 = 3'b101;
      5'd8:    begin f3 = 3'b101; f7 = 7'b0100000; end
      5'd9:    f3 = 3'b110;
      5'd10:   f3 = 3'b111;
      default: legal = 1'b0;
    endcase
    if (uop.typ != 5'd5 || uop.imm != 20'd0) legal = 1'b0;
  end

  assign enc = {f7, uop.rs2, uop.rs1, f3, uop.rd, 7'b0110011};

  // FIFO
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          xfer_in, push, pop;

  // Ready/valid come from registered count only, so there is no
  // combinational path from inst_ready to uop_ready.
  assign uop_ready  = (count != CW'(DEPTH));
  assign inst_valid = (count != '0);
  assign inst_out   = inst_valid ? mem[rd_ptr] : 32'd0;

  assign xfer_in = uop_valid & uop_ready;
  assign push    = xfer_in & legal;
  assign pop     = inst_valid & inst_ready;

  // Storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= enc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      err    <= 1'b0;
    end else begin
      err <= xfer_in & ~legal;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef INST_ENC_ERRCNT_EN
  // Counts err cycles, so it trails the err pulse by one cycle.
  always_ff @(posedge clk) begin
    if (rst)                           err_cnt <= 8'd0;
    else if (err && err_cnt != 8'hFF)  err_cnt <= err_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_inst_enc.sv
// Directed self-checking bench for inst_enc (DEPTH=4).
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_inst_enc;

  logic        clk = 1'b0;
  logic        rst;
  logic [44:0] uop_in;
  logic        uop_valid;
  logic        uop_ready;
  logic [31:0] inst_out;
  logic        inst_valid;
  logic        inst_ready;
  logic        err;
`ifdef INST_ENC_ERRCNT_EN
  logic [7:0]  err_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  inst_enc #(.DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .uop_in     (uop_in),
    .uop_valid  (uop_valid),
    .uop_ready  (uop_ready),
    .inst_out   (inst_out),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .err        (err)
`ifdef INST_ENC_ERRCNT_EN
    ,
    .err_cnt    (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [44:0] mk(input logic [4:0] rs1, input logic [4:0] rs2,
                                     input logic [4:0] rd, input logic [19:0] imm,
                                     input logic [4:0] typ, input logic [4:0] op);
    return {rs1, rs2, rd, imm, typ, op};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Hand-encoded reference words
  localparam logic [31:0] W_ADD = 32'h002081B3; // add x3,x1,x2
  localparam logic [31:0] W_SUB = 32'h407302B3; // sub x5,x6,x7
  localparam logic [31:0] W_SLL = 32'h003110B3; // sll x1,x2,x3
  localparam logic [31:0] W_XOR = 32'h00524333; // xor x6,x4,x5
  localparam logic [31:0] W_SRA = 32'h401FDFB3; // sra x31,x31,x1
  localparam logic [31:0] W_AND = 32'h00947533; // and x10,x8,x9
  localparam logic [31:0] W_SLT = 32'h0010A0B3; // slt x1,x1,x1

  initial begin
    rst = 1'b1; uop_in = '0; uop_valid = 1'b0; inst_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_uop_ready",  32'(uop_ready),  32'd1);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst_out",   inst_out,        32'd0);
    chk("rst_err",        32'(err),        32'd0);
`ifdef INST_ENC_ERRCNT_EN
    chk("rst_err_cnt",    32'(err_cnt),    32'd0);
`endif

    // add: one-cycle latency into an empty FIFO
    uop_in = mk(5'd1, 5'd2, 5'd3, 20'd0, 5'd5, 5'd1); uop_valid = 1'b1;
    step(); uop_valid = 1'b0;
    chk("add_valid", 32'(inst_valid), 32'd1);
    chk("add_word",  inst_out,        W_ADD);
    inst_ready = 1'b1; step(); inst_ready = 1'b0;
    chk("add_drained", 32'(inst_valid), 32'd0);

    // sub
    uop_in = mk(5'd6, 5'd7, 5'd5, 20'd0, 5'd5, 5'd2); uop_valid = 1'b1;
    step(); uop_valid = 1'b0;
    chk("sub_word", inst_out, W_SUB);
    inst_ready = 1'b1; step(); inst_ready = 1'b0;

    // Fill to DEPTH with the consumer stalled
    uop_valid = 1'b1;
    uop_in = mk(5'd2,  5'd3, 5'd1,  20'd0, 5'd5, 5'd3);  step();
    uop_in = mk(5'd4,  5'd5, 5'd6,  20'd0, 5'd5, 5'd6);  step();
    uop_in = mk(5'd31, 5'd1, 5'd31, 20'd0, 5'd5, 5'd8);  step();
    chk("fill3_ready", 32'(uop_ready), 32'd1);
    uop_in = mk(5'd8,  5'd9, 5'd10, 20'd0, 5'd5, 5'd10); step();
    chk("full_ready", 32'(uop_ready), 32'd0);
    // 5th (or) offered while full must be refused
    uop_in = mk(5'd1, 5'd1, 5'd1, 20'd0, 5'd5, 5'd9); step();
    uop_valid = 1'b0;
    chk("full_still", 32'(uop_ready), 32'd0);
    chk("full_hold",  inst_out,       W_SLL);
    step();
    chk("stall_hold", inst_out, W_SLL);

    inst_ready = 1'b1;
    step();
    chk("pop1_ready", 32'(uop_ready), 32'd1);
    chk("pop1_word",  inst_out,       W_XOR);
    step(); chk("pop2_word", inst_out, W_SRA);
    step(); chk("pop3_word", inst_out, W_AND);
    step(); chk("pop4_empty", 32'(inst_valid), 32'd0);
    inst_ready = 1'b0;

    // Illegal: op 11
    uop_in = mk(5'd1, 5'd2, 5'd3, 20'd0, 5'd5, 5'd11); uop_valid = 1'b1;
    step(); uop_valid = 1'b0;
    chk("ill_op_err",   32'(err),        32'd1);
    chk("ill_op_valid", 32'(inst_valid), 32'd0);
    chk("ill_op_ready", 32'(uop_ready),  32'd1);
    step();
    chk("ill_op_pulse", 32'(err), 32'd0);
    // Illegal: type 3
    uop_in = mk(5'd1, 5'd2, 5'd3, 20'd0, 5'd3, 5'd1); uop_valid = 1'b1;
    step(); uop_valid = 1'b0;
    chk("ill_type_err", 32'(err), 32'd1);
    step();
    chk("ill_type_pulse", 32'(err), 32'd0);
`ifdef INST_ENC_ERRCNT_EN
    chk("err_cnt_2", 32'(err_cnt), 32'd2);
`endif
    // Back-to-back illegal: imm != 0, then op 0
    uop_valid = 1'b1;
    uop_in = mk(5'd1, 5'd2, 5'd3, 20'd4, 5'd5, 5'd1); step();
    chk("b2b_err1", 32'(err), 32'd1);
    uop_in = mk(5'd1, 5'd2, 5'd3, 20'd0, 5'd5, 5'd0); step();
    uop_valid = 1'b0;
    chk("b2b_err2", 32'(err), 32'd1);
    step();
    chk("b2b_end",   32'(err),        32'd0);
    chk("b2b_valid", 32'(inst_valid), 32'd0);
`ifdef INST_ENC_ERRCNT_EN
    chk("err_cnt_4", 32'(err_cnt), 32'd4);
`endif

    // Push and pop together at count 2
    uop_valid = 1'b1;
    uop_in = mk(5'd1, 5'd2, 5'd3, 20'd0, 5'd5, 5'd1); step();
    uop_in = mk(5'd6, 5'd7, 5'd5, 20'd0, 5'd5, 5'd2); step();
    uop_in = mk(5'd1, 5'd1, 5'd1, 20'd0, 5'd5, 5'd4); inst_ready = 1'b1;
    step(); uop_valid = 1'b0;
    chk("simul_word",  inst_out,       W_SUB);
    chk("simul_ready", 32'(uop_ready), 32'd1);
    step(); chk("simul_word2", inst_out, W_SLT);
    step(); chk("simul_empty", 32'(inst_valid), 32'd0);
    inst_ready = 1'b0;

    // Reset with three entries queued
    uop_valid = 1'b1;
    uop_in = mk(5'd1, 5'd2, 5'd3, 20'd0, 5'd5, 5'd1); step(); step(); step();
    uop_valid = 1'b0;
    chk("pre_rst_valid", 32'(inst_valid), 32'd1);
    rst = 1'b1; step(); rst = 1'b0;
    chk("mid_rst_valid", 32'(inst_valid), 32'd0);
    chk("mid_rst_ready", 32'(uop_ready),  32'd1);
    chk("mid_rst_out",   inst_out,        32'd0);
    step();
    chk("mid_rst_stays", 32'(inst_valid), 32'd0);

`ifdef INST_ENC_ERRCNT_EN
    chk("rst_cnt_clear", 32'(err_cnt), 32'd0);
    uop_in = mk(5'd0, 5'd0, 5'd0, 20'd0, 5'd0, 5'd0); uop_valid = 1'b1;
    for (int i = 0; i < 300; i++) step();
    uop_valid = 1'b0;
    step(); step();
    chk("err_cnt_sat", 32'(err_cnt), 32'd255);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
